// File: rtl/comp_share_arbiter.sv
// Round-robin sharing of one external magnitude comparator among NREQ requesters.
// One compare in flight at a time: IDLE (grant) -> CMP (capture) -> RESP (pulse).
module comp_share_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 4,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      cmp_a,
  output logic [WIDTH-1:0]      cmp_b,
  input  logic [2:0]            cmp_r,
  output logic                  rsp_valid,
  output logic [2:0]            rsp_r,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_RESP} state_t;

  state_t           r_state, w_next;
  logic [IDW-1:0]   r_rr_ptr, r_gnt_id, r_rsp_id;
  logic [WIDTH-1:0] r_cmp_a, r_cmp_b;
  logic [2:0]       r_rsp_r;
  logic             r_err;

  logic [IDW-1:0]   w_idx, w_gnt_idx;
  logic             w_gnt_any, w_xfer, w_onehot;

  // First pending request at or above rr_ptr, wrapping; rr_ptr itself gets top priority.
  always_comb begin
    w_idx     = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_gnt_any && req_valid[w_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && r_state == S_IDLE && w_gnt_any)
      req_ready[w_gnt_idx] = 1'b1;
  end

  assign w_xfer   = (r_state == S_IDLE) && w_gnt_any;
  assign w_onehot = (cmp_r == 3'b100) || (cmp_r == 3'b010) || (cmp_r == 3'b001);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer) w_next = S_CMP;
      S_CMP:   w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_gnt_id <= '0;
      r_cmp_a  <= '0;
      r_cmp_b  <= '0;
      r_rsp_r  <= '0;
      r_rsp_id <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_xfer) begin
          r_cmp_a  <= req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
          r_cmp_b  <= req_b[int'(w_gnt_idx)*WIDTH +: WIDTH];
          r_gnt_id <= w_gnt_idx;
        end
        S_CMP: begin
          // Raw result is passed through even when malformed; err flags it stickily.
          r_rsp_r  <= cmp_r;
          r_rsp_id <= r_gnt_id;
          if (!w_onehot) r_err <= 1'b1;
        end
        S_RESP:
          r_rr_ptr <= (r_gnt_id == IDW'(NREQ-1)) ? '0 : r_gnt_id + 1'b1;
        default: ;
      endcase
    end
  end

  assign cmp_a     = r_cmp_a;
  assign cmp_b     = r_cmp_b;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_r     = r_rsp_r;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;

endmodule

// File: tb/tb_comp_share_arbiter.sv
// Directed bench for comp_share_arbiter: grants, results, fairness, cadence, fault, reset abort.
module tb_comp_share_arbiter;
  localparam int NREQ = 4, WIDTH = 4, IDW = 2;

  logic                  clk, rst_n;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0]      cmp_a, cmp_b;
  logic [2:0]            cmp_r, rsp_r;
  logic                  rsp_valid, busy, err, bad;
  logic [IDW-1:0]        rsp_id;

  int ntest = 0, nfail = 0, npulse = 0, saved;

  comp_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_r(cmp_r),
    .rsp_valid(rsp_valid), .rsp_r(rsp_r), .rsp_id(rsp_id), .busy(busy), .err(err)
  );

  // External comparator; 'bad' forces a malformed result
  assign cmp_r = bad ? 3'b011 : {cmp_a > cmp_b, cmp_a == cmp_b, cmp_a < cmp_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rsp_valid) npulse++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge of the RESP cycle.
  task automatic xfer(input string tag, input logic [3:0] v, input int exp_id, input logic [2:0] exp_r);
    int n = 0;
    req_valid = v;
    #1;
    while (!(|(req_valid & req_ready)) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_gnt"}, 32'(req_ready), 32'(1 << exp_id));
    @(negedge clk);
    chk({tag, "_cmp_busy"}, 32'(busy), 1);
    chk({tag, "_cmp_rdy"}, 32'(req_ready), 0);
    chk({tag, "_cmp_rv"}, 32'(rsp_valid), 0);
    @(negedge clk);
    chk({tag, "_rv"}, 32'(rsp_valid), 1);
    chk({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
    chk({tag, "_r"}, 32'(rsp_r), 32'(exp_r));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_rdy", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rv", 32'(rsp_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rsp", {rsp_id, rsp_r}, 0);
    chk("rst_cmp", {cmp_a, cmp_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; bad = 1'b0;
    req_valid = 4'b1111; req_a = '0; req_b = '0;
    do_reset();
    req_valid = '0;

    // 1: single request, A0=9 B0=3 -> gt
    req_a = 16'h0009; req_b = 16'h0003;
    xfer("t1", 4'b0001, 0, 3'b100);
    chk("t1_err", 32'(err), 0);
    req_valid = '0;
    @(negedge clk);
    chk("t1_post_rv", 32'(rsp_valid), 0);
    chk("t1_post_busy", 32'(busy), 0);
    chk("t1_hold_r", 32'(rsp_r), 32'b100);
    chk("t1_hold_a", 32'(cmp_a), 9);

    // 2: equal, then boundary 0 vs 15 -> lt
    req_a = 16'h0700; req_b = 16'h0700;
    xfer("t2eq", 4'b0100, 2, 3'b010);
    req_a = 16'h0000; req_b = 16'h0F00;
    xfer("t2lt", 4'b0100, 2, 3'b001);
    chk("t2_cmp_a", 32'(cmp_a), 0);
    chk("t2_cmp_b", 32'(cmp_b), 15);
    req_valid = '0;

    // 3: round robin; A=5 all, B = {0,8,5,2} -> gt,eq,lt,gt for 0..3
    do_reset();
    req_a = 16'h5555; req_b = 16'h0852;
    xfer("t3_0", 4'b1111, 0, 3'b100);
    xfer("t3_1", 4'b1111, 1, 3'b010);
    xfer("t3_2", 4'b1111, 2, 3'b001);
    xfer("t3_3", 4'b1111, 3, 3'b100);
    xfer("t3_4", 4'b1010, 1, 3'b010);
    xfer("t3_5", 4'b1010, 3, 3'b100);
    xfer("t3_6", 4'b1010, 1, 3'b010);

    // 4: continuous load from IDLE; rr_ptr=2 -> ids 2,3,0,1, one result per 3 cycles
    @(negedge clk);
    req_valid = 4'b1111;
    begin
      int ids[4] = '{2, 3, 0, 1};
      for (int c = 0; c < 12; c++) begin
        #1;
        chk("t4_busy", 32'(busy), 32'(c % 3 != 0));
        chk("t4_rv", 32'(rsp_valid), 32'(c % 3 == 2));
        if (c % 3 == 2) chk("t4_id", 32'(rsp_id), 32'(ids[c / 3]));
        @(negedge clk);
      end
    end
    req_valid = '0;

    // 5: malformed comparator result, err sticks across a good compare
    bad = 1'b1;
    xfer("t5_bad", 4'b0010, 1, 3'b011);
    chk("t5_err", 32'(err), 1);
    bad = 1'b0;
    req_a = 16'h0009; req_b = 16'h0003;
    xfer("t5_good", 4'b0001, 0, 3'b100);
    chk("t5_err_sticky", 32'(err), 1);

    // 6: reset while in CMP (rr_ptr=1 -> requester 1 in flight)
    req_a = 16'h5555; req_b = 16'h0852;
    req_valid = 4'b1111;
    @(negedge clk); #1;
    chk("t6_gnt", 32'(req_ready), 32'b0010);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    saved = npulse;
    chk("t6_rst_rv", 32'(rsp_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_err", 32'(err), 0);
    chk("t6_rst_out", {rsp_id, rsp_r, cmp_a, cmp_b}, 0);
    chk("t6_rst_rdy", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_no_pulse", 32'(npulse), 32'(saved));
    chk("t6_regrant", 32'(req_ready), 32'b0001);
    xfer("t6_x", 4'b1111, 0, 3'b100);
    req_valid = '0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
